// File: rtl/tm1638_pkg.sv
// Shared constants and state types for the TM1638 frame sequencer.
package tm1638_pkg;

  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
  localparam logic [7:0] CMD_ADDR0      = 8'hC0;
  localparam logic [7:0] CMD_DISP_ON    = 8'h88;
  localparam logic [7:0] CMD_DISP_OFF   = 8'h80;

  localparam int unsigned NUM_DIGITS     = 8;
  localparam int unsigned NUM_READ_BYTES = 4;

  // Which command of the refresh frame is in progress.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE,
    ST_DATA,
    ST_CTRL,
    ST_READ,
    ST_PUBLISH
  } frame_state_e;

  // Position inside one STB window.
  typedef enum logic [2:0] {
    PH_LEAD,   // stb low, waiting before the first clock
    PH_SHIFT,  // a byte is on the wire
    PH_TURN,   // read turnaround with dio released
    PH_TRAIL,  // last clock done, waiting to raise stb
    PH_GAP     // stb high between commands
  } cmd_phase_e;

endpackage

// File: rtl/tm1638_byte_shifter.sv
// Shifts one byte out (dir=0) or in (dir=1) LSB first on the TM1638 serial clock.
module tm1638_byte_shifter #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       dir_i,
  input  logic [7:0] tx_byte_i,
  input  logic       dio_sync_i,
  output logic       done_o,
  output logic [7:0] rx_byte_o,
  output logic       tm1638_clk_o,
  output logic       dio_out_o
);

  localparam int unsigned WW = $clog2(2 * CLK_DIV);
  localparam logic [WW-1:0] CNT_HALF = WW'(CLK_DIV - 1);
  localparam logic [WW-1:0] CNT_LAST = WW'(2 * CLK_DIV - 1);

  logic          active_q, active_d;
  logic          dir_q, dir_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          clk_q, clk_d;
  logic          dio_q, dio_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_q, rx_d;
  logic          last_cycle;

  // done and the received byte are combinational so the next byte can start
  // in the same cycle and keep the bit period unbroken across bytes.
  assign last_cycle   = active_q && (cnt_q == CNT_LAST);
  assign done_o       = last_cycle && (bit_q == 3'd7);
  assign rx_byte_o    = {dio_sync_i, rx_q[7:1]};
  assign tm1638_clk_o = clk_q;
  assign dio_out_o    = dio_q;

  // Bit timing: clock low for CLK_DIV cycles, high for CLK_DIV, sample at the end of high.
  always_comb begin
    active_d = active_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    clk_d    = clk_q;
    dio_d    = dio_q;
    shift_d  = shift_q;
    rx_d     = rx_q;
    if (start_i) begin
      active_d = 1'b1;
      dir_d    = dir_i;
      cnt_d    = '0;
      bit_d    = '0;
      clk_d    = 1'b0;
      shift_d  = tx_byte_i;
      dio_d    = dir_i ? 1'b0 : tx_byte_i[0];
    end else if (active_q) begin
      if (cnt_q == CNT_HALF) clk_d = 1'b1;
      if (last_cycle) begin
        rx_d = {dio_sync_i, rx_q[7:1]};
        if (bit_q == 3'd7) begin
          active_d = 1'b0;
        end else begin
          bit_d   = bit_q + 3'd1;
          cnt_d   = '0;
          clk_d   = 1'b0;
          shift_d = {1'b0, shift_q[7:1]};
          dio_d   = dir_q ? 1'b0 : shift_q[1];
        end
      end else begin
        cnt_d = cnt_q + WW'(1);
      end
    end
  end

  // Shifter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      clk_q    <= 1'b1;
      dio_q    <= 1'b0;
      shift_q  <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      clk_q    <= clk_d;
      dio_q    <= dio_d;
      shift_q  <= shift_d;
      rx_q     <= rx_d;
    end
  end

endmodule

// File: rtl/tm1638_frame_sequencer.sv
// Autonomous TM1638 refresh: snapshot inputs, write digits/LEDs, set brightness, read keys.
module tm1638_frame_sequencer
  import tm1638_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 8,
  parameter int unsigned REFRESH_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] seg_data,
  input  logic [7:0]  led,
  input  logic [2:0]  brightness,
  input  logic        display_on,
  output logic        tm1638_clk,
  output logic        tm1638_stb,
  input  logic        tm1638_dio_in,
  output logic        tm1638_dio_out,
  output logic        tm1638_dio_out_en,
  output logic [7:0]  keys,
  output logic        keys_valid,
  output logic        busy
);

  localparam int unsigned WW = $clog2(2 * CLK_DIV);
  localparam int unsigned TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [WW-1:0] LEAD_LAST  = WW'(CLK_DIV - 1);
  localparam logic [WW-1:0] GAP_LAST   = WW'(2 * CLK_DIV - 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(REFRESH_CYCLES - 1);

  frame_state_e  state_q, state_d;
  cmd_phase_e    phase_q, phase_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [4:0]    byte_q, byte_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          stb_q, stb_d, oe_q, oe_d, busy_q, busy_d, kv_q, kv_d;
  logic [7:0]    keys_q, keys_d, key_raw_q, key_raw_d;
  logic [63:0]   seg_q, seg_d;
  logic [7:0]    led_q, led_d;
  logic [2:0]    bright_q, bright_d;
  logic          disp_q, disp_d;
  logic          sync1_q, sync2_q;

  logic          sh_start, sh_dir, sh_done;
  logic [7:0]    sh_tx, sh_rx;
  logic [4:0]    last_byte;
  logic [3:0]    data_addr;
  logic [1:0]    rd_idx;

  tm1638_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .start_i      (sh_start),
    .dir_i        (sh_dir),
    .tx_byte_i    (sh_tx),
    .dio_sync_i   (sync2_q),
    .done_o       (sh_done),
    .rx_byte_o    (sh_rx),
    .tm1638_clk_o (tm1638_clk),
    .dio_out_o    (tm1638_dio_out)
  );

  assign tm1638_stb        = stb_q;
  assign tm1638_dio_out_en = oe_q;
  assign keys              = keys_q;
  assign keys_valid        = kv_q;
  assign busy              = busy_q;

  // Frame sequencing, STB/out_en windows and transmit byte selection.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    wait_d    = wait_q;
    byte_d    = byte_q;
    timer_d   = timer_q;
    stb_d     = stb_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    kv_d      = 1'b0;
    keys_d    = keys_q;
    key_raw_d = key_raw_q;
    seg_d     = seg_q;
    led_d     = led_q;
    bright_d  = bright_q;
    disp_d    = disp_q;
    sh_start  = 1'b0;
    sh_tx     = '0;
    sh_dir    = 1'b0;
    data_addr = '0;
    rd_idx    = 2'(byte_q - 5'd1);

    case (state_q)
      ST_DATA: last_byte = 5'(2 * NUM_DIGITS);
      ST_READ: last_byte = 5'(NUM_READ_BYTES);
      default: last_byte = '0;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (timer_q == '0) begin
          seg_d    = seg_data;
          led_d    = led;
          bright_d = brightness;
          disp_d   = display_on;
          busy_d   = 1'b1;
          state_d  = ST_MODE;
          phase_d  = PH_LEAD;
          wait_d   = '0;
          byte_d   = '0;
          stb_d    = 1'b0;
          oe_d     = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_PUBLISH: begin
        keys_d  = key_raw_q;
        kv_d    = 1'b1;
        busy_d  = 1'b0;
        timer_d = TIMER_LOAD;
        state_d = ST_IDLE;
      end
      default: begin
        case (phase_q)
          PH_LEAD: begin
            if (wait_q == LEAD_LAST) begin
              sh_start = 1'b1;
              phase_d  = PH_SHIFT;
            end else begin
              wait_d = wait_q + WW'(1);
            end
          end
          PH_TURN: begin
            if (wait_q == GAP_LAST) begin
              sh_start = 1'b1;
              phase_d  = PH_SHIFT;
            end else begin
              wait_d = wait_q + WW'(1);
            end
          end
          PH_SHIFT: begin
            if (sh_done) begin
              if (state_q == ST_READ && byte_q != '0) begin
                key_raw_d[{1'b0, rd_idx}] = sh_rx[0];
                key_raw_d[{1'b1, rd_idx}] = sh_rx[4];
              end
              if (byte_q == last_byte) begin
                phase_d = PH_TRAIL;
                wait_d  = '0;
              end else begin
                byte_d = byte_q + 5'd1;
                if (state_q == ST_READ && byte_q == '0) begin
                  phase_d = PH_TURN;
                  wait_d  = '0;
                  oe_d    = 1'b0;
                end else begin
                  sh_start = 1'b1;
                end
              end
            end
          end
          PH_TRAIL: begin
            if (wait_q == LEAD_LAST) begin
              stb_d   = 1'b1;
              oe_d    = 1'b0;
              phase_d = PH_GAP;
              wait_d  = '0;
              if (state_q == ST_READ) state_d = ST_PUBLISH;
            end else begin
              wait_d = wait_q + WW'(1);
            end
          end
          default: begin
            if (wait_q == GAP_LAST) begin
              case (state_q)
                ST_MODE: state_d = ST_DATA;
                ST_DATA: state_d = ST_CTRL;
                default: state_d = ST_READ;
              endcase
              phase_d = PH_LEAD;
              wait_d  = '0;
              byte_d  = '0;
              stb_d   = 1'b0;
              oe_d    = 1'b1;
            end else begin
              wait_d = wait_q + WW'(1);
            end
          end
        endcase
      end
    endcase

    // Transmit byte follows byte_d so a back-to-back start sends the next byte.
    data_addr = 4'(byte_d - 5'd1);
    case (state_q)
      ST_MODE: sh_tx = CMD_WRITE_AUTO;
      ST_DATA: begin
        if (byte_d == '0)         sh_tx = CMD_ADDR0;
        else if (!data_addr[0])   sh_tx = seg_q[{data_addr[3:1], 3'b000} +: 8];
        else                      sh_tx = {7'b0, led_q[data_addr[3:1]]};
      end
      ST_CTRL: sh_tx = disp_q ? (CMD_DISP_ON | {5'b0, bright_q}) : CMD_DISP_OFF;
      default: sh_tx = CMD_READ_KEYS;
    endcase
    sh_dir = (state_q == ST_READ) && (byte_d != '0);
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_LEAD;
      wait_q    <= '0;
      byte_q    <= '0;
      timer_q   <= TIMER_LOAD;
      stb_q     <= 1'b1;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      kv_q      <= 1'b0;
      keys_q    <= '0;
      key_raw_q <= '0;
      seg_q     <= '0;
      led_q     <= '0;
      bright_q  <= '0;
      disp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      wait_q    <= wait_d;
      byte_q    <= byte_d;
      timer_q   <= timer_d;
      stb_q     <= stb_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      kv_q      <= kv_d;
      keys_q    <= keys_d;
      key_raw_q <= key_raw_d;
      seg_q     <= seg_d;
      led_q     <= led_d;
      bright_q  <= bright_d;
      disp_q    <= disp_d;
    end
  end

  // Two-flop synchronizer for the asynchronous board data line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= tm1638_dio_in;
      sync2_q <= sync1_q;
    end
  end

endmodule

// File: tb/tb_tm1638_frame_sequencer.sv
// Bench: pin-level bus monitor plus board key model, frames checked against
// byte lists built from the input snapshot.
module tb_tm1638_frame_sequencer;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned REFRESH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] seg_data;
  logic [7:0]  led;
  logic [2:0]  brightness;
  logic        display_on;
  logic        tm_clk, tm_stb, dio_in, dio_out, dio_oe;
  logic [7:0]  keys;
  logic        keys_valid, busy;

  always #5 clk = ~clk;

  tm1638_frame_sequencer #(.CLK_DIV(CLK_DIV), .REFRESH_CYCLES(REFRESH)) dut (
    .clk               (clk),
    .rst               (rst),
    .seg_data          (seg_data),
    .led               (led),
    .brightness        (brightness),
    .display_on        (display_on),
    .tm1638_clk        (tm_clk),
    .tm1638_stb        (tm_stb),
    .tm1638_dio_in     (dio_in),
    .tm1638_dio_out    (dio_out),
    .tm1638_dio_out_en (dio_oe),
    .keys              (keys),
    .keys_valid        (keys_valid),
    .busy              (busy)
  );

  // Monitor state (written only by the monitor process).
  int         win_len_q[$];
  logic [7:0] mon_bytes[$];
  int         rd_q[$];
  int         wbits = 0;
  int         viol_stable = 0, viol_turn = 0, viol_rdoe = 0, viol_wroe = 0;
  int         turn_seen = 0;

  // Stimulus / checking state (written only by the main process).
  logic [7:0] board_b [4];
  int         checks = 0, failures = 0;
  int         wptr = 0, bptr = 0, turns_exp = 0;

  // Bus monitor and board model: decodes write bytes per STB window and
  // answers the key read with board_b, LSB first, changing data on clk fall.
  initial begin
    logic       p_tclk, p_stb, in_read, last_dio;
    logic [7:0] sh;
    logic [7:0] cur[$];
    int         rbit, since42;
    p_tclk = 1'b1; p_stb = 1'b1; in_read = 1'b0; last_dio = 1'b0;
    sh = '0; rbit = 0; since42 = -1;
    dio_in = 1'b0;
    forever begin
      @(negedge clk);
      if (p_stb && !tm_stb) begin
        cur.delete();
        wbits = 0; rbit = 0; since42 = -1; in_read = 1'b0; dio_in = 1'b0;
      end
      if (!tm_stb) begin
        if (since42 >= 0) begin
          since42++;
          if (since42 == 2 * CLK_DIV) begin
            turn_seen++;
            if (dio_oe !== 1'b0) viol_turn++;
          end
        end
        if (!p_tclk && tm_clk) begin
          if (in_read) begin
            if (dio_oe !== 1'b0) viol_rdoe++;
            rbit++;
          end else begin
            if (dio_oe !== 1'b1) viol_wroe++;
            sh = {dio_out, sh[7:1]};
            last_dio = dio_out;
            wbits++;
            if (wbits % 8 == 0) begin
              cur.push_back(sh);
              if (cur.size() == 1 && sh == 8'h42) begin
                in_read = 1'b1;
                since42 = 0;
              end
            end
          end
        end else if (p_tclk && tm_clk && !in_read && wbits > 0) begin
          if (dio_out !== last_dio) viol_stable++;
        end
        if (p_tclk && !tm_clk && in_read && rbit < 32) dio_in = board_b[rbit / 8][rbit % 8];
      end
      if (!p_stb && tm_stb) begin
        win_len_q.push_back(cur.size());
        foreach (cur[j]) mon_bytes.push_back(cur[j]);
        rd_q.push_back(rbit);
      end
      p_tclk = tm_clk;
      p_stb  = tm_stb;
    end
  end

  task automatic chk(input logic [63:0] got, input logic [63:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic randomize_inputs();
    seg_data   = {$urandom, $urandom};
    led        = 8'($urandom);
    brightness = 3'($urandom_range(0, 7));
    display_on = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++) board_b[i] = 8'($urandom);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(busy, 1, "busy_rise");
  endtask

  // Expected frame: 0x40 | 0xC0, digit/led pairs | control | 0x42, then keys from board bytes.
  task automatic check_frame(input logic [63:0] s, input logic [7:0] l, input logic [2:0] b,
                             input logic d);
    logic [7:0] exp_b[$];
    int         lens[4];
    logic [7:0] k;
    int         n, nw;
    lens = '{1, 2 * 8 + 1, 1, 1};
    exp_b.push_back(8'h40);
    exp_b.push_back(8'hC0);
    for (int i = 0; i < 8; i++) begin
      exp_b.push_back(s[8 * i +: 8]);
      exp_b.push_back({7'b0, l[i]});
    end
    exp_b.push_back(d ? (8'h88 | {5'b0, b}) : 8'h80);
    exp_b.push_back(8'h42);
    for (int i = 0; i < 4; i++) begin
      k[i]     = board_b[i][0];
      k[i + 4] = board_b[i][4];
    end
    n = 0;
    while (keys_valid !== 1'b1 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    turns_exp++;
    chk(keys_valid, 1, "keys_valid_seen");
    chk(keys, k, "keys");
    chk(busy, 0, "busy_low_with_valid");
    @(negedge clk);
    chk(keys_valid, 0, "keys_valid_one_cycle");
    chk(keys, k, "keys_hold");
    nw = win_len_q.size() - wptr;
    chk(nw, 4, "stb_windows");
    if (nw >= 4) begin
      for (int w = 0; w < 4; w++) chk(win_len_q[wptr + w], lens[w], $sformatf("win%0d_len", w));
      for (int j = 0; j < exp_b.size(); j++)
        if (bptr + j < mon_bytes.size()) chk(mon_bytes[bptr + j], exp_b[j], $sformatf("byte%0d", j));
      chk(rd_q[wptr + 3], 32, "read_clocks");
    end
    while (wptr < win_len_q.size()) begin
      bptr += win_len_q[wptr];
      wptr++;
    end
    chk(turn_seen, turns_exp, "turnaround_sampled");
    chk(viol_turn, 0, "oe_after_0x42");
    chk(viol_rdoe, 0, "oe_during_read");
    chk(viol_wroe, 0, "oe_during_write");
    chk(viol_stable, 0, "dio_stable_clk_high");
  endtask

  initial begin
    logic [63:0] seg_a, seg_b;
    int          n;
    rst = 1'b1;
    seg_data = 64'h3F; led = 8'h01; brightness = 3'd5; display_on = 1'b1;
    board_b[0] = 8'h01; board_b[1] = 8'h00; board_b[2] = 8'h10; board_b[3] = 8'h00;
    repeat (3) @(negedge clk);
    chk(tm_clk, 1, "rst_clk");
    chk(tm_stb, 1, "rst_stb");
    chk(dio_out, 0, "rst_dio_out");
    chk(dio_oe, 0, "rst_dio_oe");
    chk(keys, 0, "rst_keys");
    chk(keys_valid, 0, "rst_keys_valid");
    chk(busy, 0, "rst_busy");
    rst = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(n, REFRESH, "idle_after_reset");

    // Directed frame: digit0=0x3F, LED0 on, brightness 5 -> 0x8D, keys 0x41.
    check_frame(64'h3F, 8'h01, 3'd5, 1'b1);

    // Display off -> control byte 0x80.
    seg_data = {$urandom, $urandom}; led = 8'($urandom); brightness = 3'd5; display_on = 1'b0;
    for (int i = 0; i < 4; i++) board_b[i] = 8'($urandom);
    check_frame(seg_data, led, brightness, display_on);

    for (int f = 0; f < 4; f++) begin
      randomize_inputs();
      check_frame(seg_data, led, brightness, display_on);
    end

    // Inputs changing mid-frame take effect only at the next snapshot.
    seg_a = {$urandom, $urandom};
    seg_b = ~seg_a;
    seg_data = seg_a;
    wait_busy();
    repeat (200) @(negedge clk);
    seg_data = seg_b;
    check_frame(seg_a, led, brightness, display_on);
    check_frame(seg_b, led, brightness, display_on);

    // Reset in the middle of a data byte.
    board_b[0] = 8'h11;
    check_frame(seg_data, led, brightness, display_on);
    randomize_inputs();
    wait_busy();
    n = 0;
    while (!(win_len_q.size() > wptr && wbits >= 19) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(tm_stb, 0, "stb_low_in_data");
    #2 rst = 1'b1;
    #1;
    chk(tm_stb, 1, "async_rst_stb");
    chk(tm_clk, 1, "async_rst_clk");
    chk(dio_oe, 0, "async_rst_oe");
    chk(keys, 0, "async_rst_keys");
    chk(busy, 0, "async_rst_busy");
    repeat (3) @(negedge clk);
    wptr = win_len_q.size();
    bptr = mon_bytes.size();
    rst = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(n, REFRESH, "idle_after_midframe_reset");
    check_frame(seg_data, led, brightness, display_on);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tm1638_frame_sequencer.md
Name: tm1638_frame_sequencer

Overview:
- Autonomous controller for the TM1638 LED&KEY board on the shared tm1638_clk/stb/dio pins.
- Repeatedly runs a refresh frame: snapshot display inputs, write 8 digits + 8 LEDs, set brightness, read 8 keys.
- Publishes the debounce-free key state with a one-cycle valid strobe.
- Sits between lab-top display/key logic and the top-level uio pin mapping (dio is bidirectional via out/out_en).

Parameters:
CLK_DIV, 8, clk cycles per tm1638_clk phase (low and high each); minimum 4.
REFRESH_CYCLES, 50000, idle clk cycles between end of one frame and start of the next (also after reset).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active high
seg_data  input  64  digit i segments = seg_data[8*i+7:8*i], i=0..7
led  input  8  led[i] drives LED i
brightness  input  3  PWM level 0..7
display_on  input  1  0 blanks the display
tm1638_clk  output  1  serial clock, idles high
tm1638_stb  output  1  strobe, active low
tm1638_dio_in  input  1  serial data from board (asynchronous)
tm1638_dio_out  output  1  serial data to board
tm1638_dio_out_en  output  1  1 = drive dio
keys  output  8  last read key state, 1 = pressed
keys_valid  output  1  one-cycle pulse when keys updated
busy  output  1  high from frame start to keys_valid

Behaviour:
- Reset (async, any state): tm1638_clk=1, stb=1, dio_out=0, dio_out_en=0, keys=0, keys_valid=0, busy=0; FSM to IDLE, refresh timer reloaded.
- Bit timing: each bit = 2*CLK_DIV cycles; clk low CLK_DIV cycles, then high CLK_DIV cycles. dio_out changes only on the cycle clk goes low. LSB first.
- Read sampling: dio_in through 2-flop synchronizer; bit sampled on last clk cycle of the high phase.
- STB: falls CLK_DIV cycles before first clk low of a command; rises CLK_DIV cycles after last clk high; stays high ≥2*CLK_DIV cycles between commands.
- FSM states and sequence:
  - IDLE: count REFRESH_CYCLES, then latch seg_data, led, brightness, display_on; busy=1.
  - CMD_MODE: one STB window, byte 0x40 (write, auto-increment).
  - CMD_DATA: one STB window, 0xC0 followed by 16 bytes. Even address 2i = digit i segments; odd address 2i+1 = {7'b0, led[i]}.
  - CMD_CTRL: one STB window, byte 0x88|brightness if display_on, else 0x80.
  - CMD_READ: STB low, byte 0x42, then dio_out_en=0 and wait 2*CLK_DIV cycles, then clock in 4 bytes b0..b3; STB high.
  - PUBLISH: keys[i]=b_i[0], keys[i+4]=b_i[4] for i=0..3; keys_valid=1 for exactly one cycle; busy=0; back to IDLE.
- dio_out_en=1 throughout every write byte and 0 from the end of 0x42 until STB rises after the read; 0 in IDLE.
- Inputs changing mid-frame are ignored until the next snapshot.
- Only rst aborts a frame; there is no other abort input.
- keys holds its value between frames.

Decomposition:
- Package tm1638_pkg:
  - command constants CMD_WRITE_AUTO=0x40, CMD_READ_KEYS=0x42, CMD_ADDR0=0xC0, CMD_DISP_ON=0x88, CMD_DISP_OFF=0x80;
  - frame-state enum;
  - NUM_DIGITS=8, NUM_READ_BYTES=4.
- Sub-module tm1638_byte_shifter:
  - one byte TX or RX with CLK_DIV timing;
  - start/dir/tx_byte in, done/rx_byte out;
  - owns tm1638_clk and dio_out;
  - sequencer owns stb, out_en and byte indexing.

Test Plan:
- CLK_DIV=4, REFRESH_CYCLES=16; seg_data digit0=0x3F, others 0; led=0x01 -> bus monitor decodes 0x40 | 0xC0,0x3F,0x01,0x00×14 | 0x88|brightness.
- brightness=5, display_on=1 -> control byte 0x8D; display_on=0 -> 0x80.
- Board model returns 0x01,0x00,0x10,0x00 -> keys=0x41, keys_valid high exactly 1 cycle, busy falls the same cycle.
- Check dio_out_en: 0 within 2*CLK_DIV of the last 0x42 bit and for all read clocks. Check dio_out stable while tm1638_clk high on every write bit.
- Change seg_data mid-frame -> current frame's bytes unchanged; next frame carries the new values.
- Assert rst during a data byte -> same cycle: stb=1, clk=1, out_en=0, keys=0. After release: REFRESH_CYCLES idle, then a full frame restarting at 0x40.
